// File: rtl/instr_fetch_buffer_if.sv
// Bundle of the fetch buffer's two handshakes: the instruction-memory
// request/response channel and the instruction channel toward the core,
// plus the core's redirect request.
interface instr_fetch_buffer_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            instr_valid;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_ready;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   // Fetch buffer side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
   );

   // Memory and core side
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues in-order word fetches to a variable-latency
// instruction memory, queues returned words tagged with their PC and hands
// them to the core over valid/ready. A redirect flushes the queue, restarts
// fetch at the new PC and drops every response still in flight.
module instr_fetch_buffer #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                  clk,
   input logic                  rst,
   instr_fetch_buffer_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t          state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [XLEN-1:0] fifo_instr [DEPTH];
   logic [XLEN-1:0] fifo_pc    [DEPTH];

   logic            running;
   logic            flush;
   logic            accept;
   logic            drop;
   logic            push;
   logic            pop;
   logic            head_valid;
   logic [CW:0]     in_flight;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   rvalid_w;
   logic [CW-1:0]   accept_w;
   logic [CW-1:0]   push_w;
   logic [CW-1:0]   pop_w;

   // Per-cycle handshake decisions; a response in a redirect cycle is always dropped
   always_comb begin
      running    = (state == RUN);
      flush      = running && bus.redirect;
      in_flight  = {1'b0, count} + {1'b0, outstanding};
      head_valid = (count != '0);
      accept     = bus.imem_req && bus.imem_ready;
      drop       = bus.imem_rvalid && (flush || (discard != '0));
      push       = bus.imem_rvalid && !drop;
      pop        = head_valid && bus.instr_ready && !flush;
      target_pc  = bus.redirect_pc & ~(XLEN'(3));
      rvalid_w   = CW'(bus.imem_rvalid);
      accept_w   = CW'(accept);
      push_w     = CW'(push);
      pop_w      = CW'(pop);
   end

   assign bus.imem_req    = running && !bus.redirect && (in_flight < CAP);
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head_valid ? fifo_instr[rd_ptr] : '0;
   assign bus.instr_pc    = head_valid ? fifo_pc[rd_ptr]    : '0;

   // Control state: boot FSM, fetch/response PCs, occupancy and discard bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= RUN;
            default: state <= BOOT;
         endcase

         if (flush) begin
            // Everything still in flight after this edge is stale, and the
            // discard count already covers a subset of those same requests,
            // so the new count is simply what remains outstanding.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            count       <= '0;
            rd_ptr      <= wr_ptr;
            outstanding <= outstanding - rvalid_w;
            discard     <= outstanding - rvalid_w;
         end else begin
            outstanding <= outstanding + accept_w - rvalid_w;
            count       <= count + push_w - pop_w;
            if (accept) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (drop) begin
               discard <= discard - CW'(1);
            end
            if (push) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + XLEN'(4);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

   // Queue storage: capture each kept response word together with its PC
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.imem_rdata;
         fifo_pc[wr_ptr]    <= resp_pc;
      end
   end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for the instruction fetch buffer: a variable-latency memory
// model that returns the word address as data, a consumer-side scoreboard of
// expected PCs, and a linear sequence of reset, back-pressure, redirect and
// asynchronous-reset scenarios.
module tb_instr_fetch_buffer;
   logic clk;
   logic rst;

   instr_fetch_buffer_if #(.XLEN(32)) tbIf ();

   instr_fetch_buffer #(
      .XLEN(32),
      .DEPTH(4),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(tbIf.master)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pendQ[$];
   logic [31:0] expQ[$];
   logic [31:0] expPc;
   logic [31:0] lastAccAddr;
   int          memLat;
   int          cyc;
   int          nAccepted;
   int          accBase;
   int          nPopped;
   int          nCompared;
   int          nMismatch;
   logic        found;

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hang guard
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatch++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
      tbIf.instr_ready = ready;
      tbIf.redirect    = redir;
      tbIf.redirect_pc = rpc;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic loadExpected(input logic [31:0] base);
      expQ.delete();
      for (int i = 0; i < 64; i++) begin
         expQ.push_back(base + 32'(4 * i));
      end
   endtask

   task automatic doReset(input logic ready, input logic [31:0] base);
      @(posedge clk);
      #3;
      rst = 1'b0;
      applyStimulus(ready, 1'b0, 32'h0);
      loadExpected(base);
      nextCycle();
      nextCycle();
      rst = 1'b1;
   endtask

   task automatic waitForValid(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         nextCycle();
         #1;
         if (tbIf.instr_valid) seen = 1'b1;
      end
      checkOutput(tag, {31'b0, seen}, 32'h1);
   endtask

   // Memory model: in-order responses memLat cycles after acceptance, data = address
   initial begin
      tbIf.imem_rvalid = 1'b0;
      tbIf.imem_rdata  = '0;
      cyc              = 0;
      nAccepted        = 0;
      lastAccAddr      = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            pendQ.delete();
            tbIf.imem_rvalid = 1'b0;
            tbIf.imem_rdata  = '0;
         end else if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            tbIf.imem_rvalid = 1'b1;
            tbIf.imem_rdata  = pendQ[0].addr;
            void'(pendQ.pop_front());
         end else begin
            tbIf.imem_rvalid = 1'b0;
            tbIf.imem_rdata  = '0;
         end
         @(negedge clk);
         if (!rst) begin
            pendQ.delete();
         end else if (tbIf.imem_req && tbIf.imem_ready) begin
            pendQ.push_back('{tbIf.imem_addr, cyc + memLat});
            nAccepted++;
            lastAccAddr = tbIf.imem_addr;
         end
      end
   end

   // Consumer-side scoreboard: every accepted instruction must be the next expected PC
   initial begin
      nPopped = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tbIf.instr_valid && tbIf.instr_ready && !tbIf.redirect) begin
            nCompared++;
            assert (expQ.size() != 0) else begin
               nMismatch++;
               $error("[TB] FAIL unexpectedPop: observed pc 0x%0h expected no output",
                      tbIf.instr_pc);
            end
            if (expQ.size() != 0) begin
               expPc = expQ.pop_front();
               checkOutput("popPc", tbIf.instr_pc, expPc);
               checkOutput("popInstr", tbIf.instr, expPc);
               nPopped++;
            end
         end
      end
   end

   // Directed scenario sequence
   initial begin
      nCompared       = 0;
      nMismatch       = 0;
      memLat          = 1;
      rst             = 1'b0;
      tbIf.imem_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);

      // Reset values, then release with a one-cycle memory and the core always ready
      nextCycle();
      nextCycle();
      #1;
      checkOutput("rstImemReq", {31'b0, tbIf.imem_req}, 32'h0);
      checkOutput("rstImemAddr", tbIf.imem_addr, 32'h0);
      checkOutput("rstInstrValid", {31'b0, tbIf.instr_valid}, 32'h0);
      checkOutput("rstInstr", tbIf.instr, 32'h0);
      checkOutput("rstInstrPc", tbIf.instr_pc, 32'h0);
      loadExpected(32'h0);
      rst = 1'b1;
      #1;
      checkOutput("bootNoReq", {31'b0, tbIf.imem_req}, 32'h0);
      nextCycle();
      #1;
      checkOutput("firstReq", {31'b0, tbIf.imem_req}, 32'h1);
      checkOutput("firstAddr", tbIf.imem_addr, 32'h0);
      nextCycle();
      #1;
      checkOutput("secondAddr", tbIf.imem_addr, 32'h4);
      checkOutput("notYetValid", {31'b0, tbIf.instr_valid}, 32'h0);
      nextCycle();
      #1;
      checkOutput("firstValid", {31'b0, tbIf.instr_valid}, 32'h1);
      checkOutput("firstPc", tbIf.instr_pc, 32'h0);
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         #1;
         checkOutput("streamValid", {31'b0, tbIf.instr_valid}, 32'h1);
      end

      // Back-pressure: exactly DEPTH requests, then one more after a single pop
      doReset(1'b0, 32'h0);
      accBase = nAccepted;
      repeat (9) nextCycle();
      #1;
      checkOutput("capAccepts", 32'(nAccepted - accBase), 32'd4);
      checkOutput("capLastAddr", lastAccAddr, 32'hC);
      checkOutput("capNoReq", {31'b0, tbIf.imem_req}, 32'h0);
      checkOutput("capHeadPc", tbIf.instr_pc, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("refillReq", {31'b0, tbIf.imem_req}, 32'h1);
      checkOutput("refillAddr", tbIf.imem_addr, 32'h10);
      checkOutput("afterPopHead", tbIf.instr_pc, 32'h4);
      nextCycle();
      nextCycle();
      #1;
      checkOutput("refillAccepts", 32'(nAccepted - accBase), 32'd5);
      checkOutput("refillCapReq", {31'b0, tbIf.imem_req}, 32'h0);

      // Three-cycle memory, redirect with two requests outstanding
      memLat = 3;
      doReset(1'b1, 32'h0);
      nextCycle();
      nextCycle();
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h100);
      loadExpected(32'h100);
      #1;
      checkOutput("redirNoReq", {31'b0, tbIf.imem_req}, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("redirEmpty", {31'b0, tbIf.instr_valid}, 32'h0);
      checkOutput("redirAddr", tbIf.imem_addr, 32'h100);
      checkOutput("redirReq", {31'b0, tbIf.imem_req}, 32'h1);
      waitForValid("redirValidTimeout", 20);
      checkOutput("redirFirstPc", tbIf.instr_pc, 32'h100);
      repeat (6) nextCycle();

      // Redirect coinciding with a response and a pop
      memLat = 2;
      repeat (10) nextCycle();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         nextCycle();
         #1;
         if (tbIf.instr_valid && tbIf.imem_rvalid) found = 1'b1;
      end
      applyStimulus(1'b1, 1'b1, 32'h300);
      loadExpected(32'h300);
      checkOutput("collideFound", {31'b0, found}, 32'h1);
      #1;
      checkOutput("collideNoReq", {31'b0, tbIf.imem_req}, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("collideEmpty", {31'b0, tbIf.instr_valid}, 32'h0);
      checkOutput("collideAddr", tbIf.imem_addr, 32'h300);
      waitForValid("collideValidTimeout", 20);
      checkOutput("collideFirstPc", tbIf.instr_pc, 32'h300);
      repeat (3) nextCycle();

      // Unaligned redirect target
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h203);
      loadExpected(32'h200);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("alignAddr", tbIf.imem_addr, 32'h200);
      checkOutput("alignEmpty", {31'b0, tbIf.instr_valid}, 32'h0);
      waitForValid("alignValidTimeout", 20);
      checkOutput("alignFirstPc", tbIf.instr_pc, 32'h200);
      checkOutput("alignFirstInstr", tbIf.instr, 32'h200);

      // Asynchronous reset between clock edges while streaming
      memLat = 1;
      repeat (6) nextCycle();
      @(posedge clk);
      #2;
      checkOutput("preResetValid", {31'b0, tbIf.instr_valid}, 32'h1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("asyncImemReq", {31'b0, tbIf.imem_req}, 32'h0);
      checkOutput("asyncImemAddr", tbIf.imem_addr, 32'h0);
      checkOutput("asyncValid", {31'b0, tbIf.instr_valid}, 32'h0);
      checkOutput("asyncInstr", tbIf.instr, 32'h0);
      checkOutput("asyncInstrPc", tbIf.instr_pc, 32'h0);
      loadExpected(32'h0);
      nextCycle();
      nextCycle();
      rst = 1'b1;
      nextCycle();
      #1;
      checkOutput("restartReq", {31'b0, tbIf.imem_req}, 32'h1);
      checkOutput("restartAddr", tbIf.imem_addr, 32'h0);
      waitForValid("restartValidTimeout", 20);
      checkOutput("restartFirstPc", tbIf.instr_pc, 32'h0);
      repeat (6) nextCycle();
      checkOutput("enoughPops", {31'b0, (nPopped >= 30)}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
